alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CNT_W, default 16, width of retired-operation counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream presents an operation.
REQ-006 in_ready  output  1  stage can accept an operation this cycle.
REQ-007 alu_control  input  3  op code from ALU decoder: 000 ADD, 001 SUB, 010 XOR-compare, 011 OR, 100 AND, 101 SLT; 110/111 illegal.
REQ-008 op_a, op_b  input  WIDTH each  operands.
REQ-009 out_valid  output  1  result registers hold a valid result.
REQ-010 out_ready  input  1  downstream accepts result this cycle.
REQ-011 result  output  WIDTH  registered ALU result.
REQ-012 zero  output  1  registered (result == 0).
REQ-013 illegal  output  1  registered; alu_control was 110 or 111.
REQ-014 op_count  output  CNT_W  number of results handed downstream.

Function
REQ-015 Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
REQ-016 ADD: a+b mod 2^WIDTH; SUB: a-b mod 2^WIDTH; XOR-compare: a^b (zero=1 iff a==b, branch use); OR, AND bitwise; SLT: signed two's-complement a<b -> 1 zero-extended, else 0.
REQ-017 Illegal codes: result 0, zero 1, illegal 1; no other side effect.
REQ-018 Latency: result of an accepted op is visible with out_valid=1 exactly one cycle after acceptance when the output slot is free.
REQ-019 Storage: one output register plus one skid register (two entries total); states EMPTY (0 held), ONE (output only), FULL (output + skid).
REQ-020 in_ready is driven from a register only: in_ready = 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-021 EMPTY: transfer in -> ONE.
REQ-022 ONE: in only -> FULL if out_ready=0, ONE if out_ready=1 (output reloads with new result); out only -> EMPTY; both -> ONE with new result; neither -> ONE, held.
REQ-023 FULL: transfer out -> skid entry moves to output register, state ONE; else hold; in_valid ignored.
REQ-024 Order preserved: results leave in acceptance order; no drop, no duplicate.
REQ-025 result/zero/illegal stable while out_valid=1 and out_ready=0.
REQ-026 op_count increments by 1 on each transfer out, wraps 2^CNT_W-1 -> 0.
REQ-027 Operands and alu_control sampled only on transfer in; values on other cycles ignored.

Reset
REQ-028 rst_n=0 at a rising edge: state EMPTY, out_valid 0, in_ready 1, result 0, zero 0, illegal 0, op_count 0.
REQ-029 Reset mid-operation discards held results (output and skid) with no transfer out; in-flight in transfer on that edge is dropped.
REQ-030 in_ready reads 1 in the first cycle after reset deasserts.

Structure
REQ-031 Shared package holds the 3-bit alu_control code constants (ADD, SUB, XOR_CMP, OR, AND, SLT) used by both the decoder and this stage, and the state encoding.
REQ-032 One combinational sub-module alu_core (WIDTH-parameterised: alu_control, a, b -> result, zero, illegal) is instantiated once on the input path; alu_exec_stage contains only handshake, skid and counter logic.

Verification
REQ-033 Single op: ADD a=5, b=7, out_ready=1 -> next cycle out_valid=1, result=12, zero=0, op_count=1.
REQ-034 Arithmetic edges: SUB 3-5 -> 0xFFFFFFFE; SLT a=0xFFFFFFFF b=1 -> 1; SLT a=1 b=0xFFFFFFFF -> 0; XOR-compare a=b=0xA5 -> result 0, zero=1; code 111 -> result 0, illegal=1.
REQ-035 Backpressure: out_ready=0, issue ops A,B back-to-back -> in_ready 0 after B accepted; C held off; raise out_ready -> A, B, C emitted in order, values unchanged during stall.
REQ-036 Simultaneous in/out in ONE each cycle, streaming 100 random ops with out_ready=1 -> throughput 1/cycle, in_ready constant 1, results match reference model.
REQ-037 Random out_ready/in_valid 10k cycles -> scoreboard order and values match, op_count equals transfers out mod 2^16; preload op_count near 0xFFFF -> wraps to 0.
REQ-038 Assert rst_n=0 in FULL state -> next cycle out_valid 0, in_ready 1, op_count 0, no stale result emitted after release.

Source files
------------

// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the ALU decoder and the ALU execute stage.
//   - 3-bit alu_control op codes (110/111 are illegal)
//   - execute-stage occupancy state encoding
package alu_exec_stage_pkg;

    typedef logic [2:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD     = 3'b000;
    localparam alu_ctrl_t ALU_SUB     = 3'b001;
    localparam alu_ctrl_t ALU_XOR_CMP = 3'b010;
    localparam alu_ctrl_t ALU_OR      = 3'b011;
    localparam alu_ctrl_t ALU_AND     = 3'b100;
    localparam alu_ctrl_t ALU_SLT     = 3'b101;

    // Occupancy of the output + skid register pair.
    localparam logic [1:0] ST_EMPTY = 2'd0;  // nothing held
    localparam logic [1:0] ST_ONE   = 2'd1;  // output register only
    localparam logic [1:0] ST_FULL  = 2'd2;  // output + skid register

endpackage

// File: rtl/alu_exec_stage_alu_core.sv
// alu_core: purely combinational ALU used on the input side of the stage.
// Ports:
//   alu_control_i  op code (see alu_exec_stage_pkg)
//   a_i, b_i       operands
//   result_o       ALU result (0 for illegal codes)
//   zero_o         result_o == 0
//   illegal_o      op code was 110 or 111
module alu_core
    import alu_exec_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       alu_control_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             illegal_o
);

    logic slt;

    assign slt = ($signed(a_i) < $signed(b_i));

    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        case (alu_control_i)
            ALU_ADD:     result_o = a_i + b_i;
            ALU_SUB:     result_o = a_i - b_i;
            ALU_XOR_CMP: result_o = a_i ^ b_i;
            ALU_OR:      result_o = a_i | b_i;
            ALU_AND:     result_o = a_i & b_i;
            ALU_SLT:     result_o = {{(WIDTH-1){1'b0}}, slt};
            default:     illegal_o = 1'b1;
        endcase
    end

    // Illegal codes force result to 0, so zero reads 1 for them as well.
    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered ALU execute stage with a two-entry
// (output + skid) buffer and a retired-operation counter.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid / in_ready     upstream handshake (in_ready is a pure register)
//   alu_control, op_a, op_b operation, sampled only on an input transfer
//   out_valid / out_ready   downstream handshake
//   result, zero, illegal   registered ALU outputs, stable while stalled
//   op_count                number of results handed downstream (wraps)
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [CNT_W-1:0] op_count
);

    logic [1:0]       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] out_res_q, out_res_d;
    logic             out_zero_q, out_zero_d;
    logic             out_ill_q, out_ill_d;
    logic [WIDTH-1:0] skid_res_q, skid_res_d;
    logic             skid_zero_q, skid_zero_d;
    logic             skid_ill_q, skid_ill_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic [WIDTH-1:0] core_res;
    logic             core_zero;
    logic             core_ill;
    logic             in_fire;
    logic             out_fire;
    logic             load_out;
    logic             load_skid;
    logic             skid_to_out;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .alu_control_i (alu_control),
        .a_i           (op_a),
        .b_i           (op_b),
        .result_o      (core_res),
        .zero_o        (core_zero),
        .illegal_o     (core_ill)
    );

    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid && in_ready_q;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    load_out = 1'b1;
                    state_d  = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    load_out = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_d   = ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    skid_to_out = 1'b1;
                    state_d     = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_res_d   = out_res_q;
        out_zero_d  = out_zero_q;
        out_ill_d   = out_ill_q;
        skid_res_d  = skid_res_q;
        skid_zero_d = skid_zero_q;
        skid_ill_d  = skid_ill_q;
        if (load_out) begin
            out_res_d  = core_res;
            out_zero_d = core_zero;
            out_ill_d  = core_ill;
        end else if (skid_to_out) begin
            out_res_d  = skid_res_q;
            out_zero_d = skid_zero_q;
            out_ill_d  = skid_ill_q;
        end
        if (load_skid) begin
            skid_res_d  = core_res;
            skid_zero_d = core_zero;
            skid_ill_d  = core_ill;
        end
    end

    // in_ready is registered from the next state, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready_d = (state_d != ST_FULL);
    assign op_count_d = out_fire ? op_count_q + CNT_W'(1) : op_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_res_q   <= '0;
            out_zero_q  <= 1'b0;
            out_ill_q   <= 1'b0;
            skid_res_q  <= '0;
            skid_zero_q <= 1'b0;
            skid_ill_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_res_q   <= out_res_d;
            out_zero_q  <= out_zero_d;
            out_ill_q   <= out_ill_d;
            skid_res_q  <= skid_res_d;
            skid_zero_q <= skid_zero_d;
            skid_ill_q  <= skid_ill_d;
            op_count_q  <= op_count_d;
        end
    end

    assign in_ready = in_ready_q;
    assign result   = out_res_q;
    assign zero     = out_zero_q;
    assign illegal  = out_ill_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage. Accepted ops are pushed into a
// queue of expected results; a monitor pops and compares on each output
// transfer and also tracks buffer occupancy as a plain 2-entry FIFO.
module tb_alu_exec_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_control;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic [15:0] op_count;

    // Narrow-counter copy on the same stimulus, used to observe wrap-around.
    logic        in_ready_s;
    logic        out_valid_s;
    logic [31:0] result_s;
    logic        zero_s;
    logic        illegal_s;
    logic [3:0]  op_count_s;

    alu_exec_stage #(.WIDTH(32), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .illegal(illegal), .op_count(op_count)
    );

    alu_exec_stage #(.WIDTH(32), .CNT_W(4)) u_dut_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .alu_control(alu_control), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid_s), .out_ready(out_ready), .result(result_s),
        .zero(zero_s), .illegal(illegal_s), .op_count(op_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   in_acc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU computed with 64-bit integer arithmetic.
    function automatic exp_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint la, lb, sa, sb2;
        la  = longint'(a);
        lb  = longint'(b);
        sa  = a[31] ? la - 64'sh1_0000_0000 : la;
        sb2 = b[31] ? lb - 64'sh1_0000_0000 : lb;
        e.ill = (c > 3'd5);
        case (c)
            3'd0:    e.res = 32'((la + lb) % 64'sh1_0000_0000);
            3'd1:    e.res = 32'((la - lb + 64'sh1_0000_0000) % 64'sh1_0000_0000);
            3'd2:    e.res = a ^ b;
            3'd3:    e.res = a | b;
            3'd4:    e.res = a & b;
            3'd5:    e.res = (sa < sb2) ? 32'd1 : 32'd0;
            default: e.res = 32'd0;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Stimulus side of the scoreboard: every accepted op queues its answer.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            sb.push_back(model(alu_control, op_a, op_b));
            in_acc++;
        end
    end

    // Monitor.
    int          occ = 0;
    int          out_cnt = 0;
    logic        stall_prev = 1'b0;
    logic        post_rst = 1'b0;
    logic [31:0] res_prev;
    logic        z_prev;
    logic        i_prev;
    exp_t        got;

    always @(negedge clk) begin
        if (!rst_n) begin
            occ        = 0;
            out_cnt    = 0;
            stall_prev = 1'b0;
            post_rst   = 1'b1;
            sb.delete();
        end else begin
            if (post_rst) begin
                check("rst_result", 64'(result), 64'd0);
                check("rst_zero", 64'(zero), 64'd0);
                check("rst_illegal", 64'(illegal), 64'd0);
                post_rst = 1'b0;
            end
            check("in_ready", 64'(in_ready), 64'(occ < 2));
            check("out_valid", 64'(out_valid), 64'(occ > 0));
            check("op_count", 64'(op_count), 64'(out_cnt[15:0]));
            check("op_count_w4", 64'(op_count_s), 64'(out_cnt[3:0]));
            if (stall_prev) begin
                check("stall_result", 64'(result), 64'(res_prev));
                check("stall_zero", 64'(zero), 64'(z_prev));
                check("stall_illegal", 64'(illegal), 64'(i_prev));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    got = sb.pop_front();
                    check("sb_result", 64'(result), 64'(got.res));
                    check("sb_zero", 64'(zero), 64'(got.z));
                    check("sb_illegal", 64'(illegal), 64'(got.ill));
                end
                out_cnt++;
                occ--;
            end
            if (in_valid && in_ready) occ++;
            stall_prev = out_valid && !out_ready;
            res_prev   = result;
            z_prev     = zero;
            i_prev     = illegal;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single op into an empty stage with out_ready=1; checks fixed answers.
    task automatic dir_op(input string name, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ez,
                          input logic ei);
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        alu_control = c;
        op_a        = a;
        op_b        = b;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_result"}, 64'(result), 64'(er));
        check({name, "_zero"}, 64'(zero), 64'(ez));
        check({name, "_illegal"}, 64'(illegal), 64'(ei));
        step();
    endtask

    task automatic set_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        alu_control = c;
        op_a        = a;
        op_b        = b;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc0;
        bit  done;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        alu_control = 3'd0;
        op_a        = 32'd0;
        op_b        = 32'd0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Single op and arithmetic edge cases.
        dir_op("add", 3'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        @(negedge clk);
        check("add_op_count", 64'(op_count), 64'd1);
        step();
        dir_op("sub", 3'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0);
        dir_op("slt_neg", 3'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        dir_op("slt_pos", 3'd5, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        dir_op("xor_eq", 3'd2, 32'hA5, 32'hA5, 32'd0, 1'b1, 1'b0);
        dir_op("ill7", 3'd7, 32'h1234, 32'h5678, 32'd0, 1'b1, 1'b1);
        dir_op("ill6", 3'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1);
        dir_op("or", 3'd3, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0);
        dir_op("and", 3'd4, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0);

        // Backpressure: A, B fill the stage, C is held off.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_op(3'd0, 32'd100, 32'd1);
        step();
        set_op(3'd1, 32'd50, 32'd8);
        step();
        set_op(3'd3, 32'h10, 32'h01);
        @(negedge clk);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_result_a", 64'(result), 64'd101);
        step();
        acc0 = in_acc;
        repeat (3) step();
        check("bp_c_held", 64'(in_acc), 64'(acc0));
        out_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("bp_c_accepted", 64'(in_acc), 64'(acc0 + 1));
        repeat (5) step();
        check("bp_drained", 64'(sb.size()), 64'd0);

        // Streaming: one op per cycle with out_ready held high.
        acc0      = in_acc;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            set_op(3'($urandom_range(0, 5)), $urandom, $urandom);
            step();
        end
        in_valid = 1'b0;
        check("stream_throughput", 64'(in_acc - acc0), 64'd100);
        repeat (4) step();

        // Random handshakes on both sides.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            alu_control = 3'($urandom_range(0, 7));
            op_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            op_b = ($urandom_range(0, 3) == 0) ? op_a : $urandom;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        check("rand_drained", 64'(sb.size()), 64'd0);

        // Reset while FULL discards both held results.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_op(3'd0, 32'd1, 32'd2);
        step();
        set_op(3'd0, 32'd3, 32'd4);
        step();
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'd0);
        step();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        step();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_op_count", 64'(op_count), 64'd0);
        step();
        repeat (5) step();
        check("rst_no_stale", 64'(op_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
